// File: rtl/rdcla_kpg_sum_decoder_if.sv
// Handshake bus for the RDCLA sum decoder: KPG/propagate request side and
// sum/flags response side, plus the running error count.
interface rdcla_kpg_sum_decoder_if #(
  parameter int N         = 8,
  parameter int ERR_CNT_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*(N+1)-1:0]     kpg_in;
  logic [N-1:0]           p_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [N-1:0]           sum;
  logic                   cout;
  logic                   ovf;
  logic                   kpg_err;
  logic [ERR_CNT_W-1:0]   err_cnt;

  modport master (
    output in_valid, kpg_in, p_in, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, kpg_err, err_cnt
  );

  modport slave (
    input  in_valid, kpg_in, p_in, out_ready,
    output in_ready, out_valid, sum, cout, ovf, kpg_err, err_cnt
  );
endinterface

// File: rtl/rdcla_kpg_sum_decoder.sv
// Back end of the recursive-doubling CLA: decodes the resolved KPG carries,
// forms sum/cout/ovf, flags unresolved fields, 2-stage valid/ready pipe.

// One KPG field -> carry bit plus "still unresolved" flag (01/10 decode as 0).
module rdcla_kpg_field_dec (
  input  logic [1:0] fld_i,
  output logic       c_o,
  output logic       unres_o
);
  assign c_o     = fld_i[1] & fld_i[0];
  assign unres_o = fld_i[1] ^ fld_i[0];
endmodule

module rdcla_kpg_sum_decoder #(
  parameter int N         = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rdcla_kpg_sum_decoder_if.slave   bus
);
  localparam int KW     = 2 * (N + 1);
  localparam int STAGES = 2;

  // vld_pipe_q[1] = S1 holds a transaction, vld_pipe_q[2] = S2 (out_valid)
  logic [STAGES:1]        vld_pipe_q, vld_pipe_d;
  logic [KW-1:0]          s1_kpg_q, s1_kpg_d;
  logic [N-1:0]           s1_p_q, s1_p_d;
  logic [N-1:0]           sum_q, sum_d;
  logic                   cout_q, cout_d;
  logic                   ovf_q, ovf_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [N:0]             c;
  logic [N:0]             unres;
  logic                   s2_adv;
  logic                   in_acc;
  logic                   out_xfer;

  // S2 may load whenever it is empty or its contents leave this cycle
  assign out_xfer = vld_pipe_q[2] & bus.out_ready;
  assign s2_adv   = ~vld_pipe_q[2] | bus.out_ready;
  assign bus.in_ready = ~vld_pipe_q[1] | s2_adv;
  assign in_acc   = bus.in_valid & bus.in_ready;

  genvar j;
  generate
    for (j = 0; j <= N; j++) begin : g_fld
      rdcla_kpg_field_dec u_dec (
        .fld_i   (s1_kpg_q[2*j+1:2*j]),
        .c_o     (c[j]),
        .unres_o (unres[j])
      );
    end
  endgenerate

  // Next-state for both stages and the saturating error counter
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_kpg_d   = s1_kpg_q;
    s1_p_d     = s1_p_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;

    if (bus.in_ready) vld_pipe_d[1] = bus.in_valid;
    if (in_acc) begin
      s1_kpg_d = bus.kpg_in;
      s1_p_d   = bus.p_in;
    end

    if (s2_adv) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) begin
        sum_d  = s1_p_q ^ c[N-1:0];
        cout_d = c[N];
        ovf_d  = c[N-1] ^ c[N];
        err_d  = |unres;
      end
    end

    // counted on the transfer itself, so a stalled error is counted once
    if (out_xfer && err_q && (err_cnt_q != {ERR_CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  // Pipeline and counter registers, synchronous reset drops in-flight work
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_kpg_q   <= '0;
      s1_p_q     <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_kpg_q   <= s1_kpg_d;
      s1_p_q     <= s1_p_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.out_valid = vld_pipe_q[2];
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.kpg_err   = err_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_rdcla_kpg_sum_decoder.sv
// Directed bench for rdcla_kpg_sum_decoder (N=8): vector table, stall,
// saturation and mid-stall reset, with an in-order output scoreboard.
module tb_rdcla_kpg_sum_decoder;
  logic clk;
  logic rst_n;

  rdcla_kpg_sum_decoder_if #(.N(8), .ERR_CNT_W(8)) bus ();

  rdcla_kpg_sum_decoder #(.N(8), .ERR_CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] kpg;
    logic [7:0]  p;
    logic [7:0]  sum;
    logic        cout;
    logic        ovf;
    logic        err;
  } vec_t;

  vec_t     exp_q[$];
  vec_t     tbl[8];
  int       n_tests = 0;
  int       n_fail  = 0;
  int       model_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: every output transfer must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_output: got sum 0x%0h with nothing expected", bus.sum);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        check("sb_sum",  {24'd0, bus.sum}, {24'd0, e.sum});
        check("sb_cout", {31'd0, bus.cout}, {31'd0, e.cout});
        check("sb_ovf",  {31'd0, bus.ovf}, {31'd0, e.ovf});
        check("sb_err",  {31'd0, bus.kpg_err}, {31'd0, e.err});
        check("sb_err_cnt", {24'd0, bus.err_cnt}, model_cnt);
        if (e.err && model_cnt < 255) model_cnt++;
      end
    end
  end

  task automatic send(input vec_t v);
    bit acc;
    int guard;
    bus.in_valid = 1'b1;
    bus.kpg_in   = v.kpg;
    bus.p_in     = v.p;
    exp_q.push_back(v);
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      guard++;
    end
    n_tests++;
    if (!acc) begin
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    model_cnt = 0;
  endtask

  initial begin
    vec_t a, b, cc, d, snap_chk;
    bus.in_valid  = 1'b0;
    bus.kpg_in    = '0;
    bus.p_in      = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    //          kpg       p      sum    cout  ovf   err
    tbl[0] = '{18'h0FFFC, 8'h7E, 8'h80, 1'b0, 1'b1, 1'b0}; // 0x7F+0x01
    tbl[1] = '{18'h3FFFC, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0}; // 0xFF+0x01
    tbl[2] = '{18'h00003, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0}; // 0+0, cin=1
    tbl[3] = '{18'h00040, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b1}; // field 3 = 01
    tbl[4] = '{18'h30000, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0}; // 0x80+0x80
    tbl[5] = '{18'h00000, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b0}; // all kill
    tbl[6] = '{18'h00002, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1}; // cin field 10
    tbl[7] = '{18'h10000, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1}; // field 8 = 01

    do_reset(2);
    @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_err_cnt",   {24'd0, bus.err_cnt}, 0);
    check("rst_in_ready",  {31'd0, bus.in_ready}, 1);
    check("rst_sum",       {24'd0, bus.sum}, 0);
    @(posedge clk); #1;

    // Table: one at a time, checking the 2-cycle latency
    for (int i = 0; i < 8; i++) begin
      send(tbl[i]);
      @(negedge clk);
      check("lat_not_1", {31'd0, bus.out_valid}, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("lat_2", {31'd0, bus.out_valid}, 1);
      @(posedge clk); #1;
    end
    drain();
    check("tbl_err_cnt", {24'd0, bus.err_cnt}, 3);

    // Single error transaction from a clean counter
    do_reset(1);
    send(tbl[3]);
    drain();
    check("err_cnt_one", {24'd0, bus.err_cnt}, 1);

    // Stream of 4 with a 3-cycle stall after the first output
    a  = '{18'h0FFFC, 8'h7E, 8'h80, 1'b0, 1'b1, 1'b0};
    b  = '{18'h3FFFC, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0};
    cc = '{18'h00003, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0};
    d  = '{18'h00000, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0};
    bus.out_ready = 1'b0;
    send(a);
    send(b);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid",    {31'd0, bus.out_valid}, 1);
      check("stall_in_ready", {31'd0, bus.in_ready}, 0);
      check("stall_sum",      {24'd0, bus.sum}, 32'h80);
      check("stall_ovf",      {31'd0, bus.ovf}, 1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(cc);
    send(d);
    drain();

    // Saturation: 300 back-to-back error transactions
    for (int k = 0; k < 300; k++) send(tbl[3]);
    drain();
    check("err_cnt_sat", {24'd0, bus.err_cnt}, 32'hFF);

    // Reset during a stall discards in-flight work
    bus.out_ready = 1'b0;
    send(a);
    send(b);
    do_reset(1);
    @(negedge clk);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("mid_rst_err_cnt",   {24'd0, bus.err_cnt}, 0);
    check("mid_rst_in_ready",  {31'd0, bus.in_ready}, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    snap_chk = '{18'h00000, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0};
    send(snap_chk);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
